// File: rtl/riscy_pkg.sv
// Shared RV32 core definitions: load/store FSM states, funct3 encodings, byte-enable
// patterns and access-size helpers used by the load/store path.
package riscy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // funct3[1] set means word, which also folds the undefined 011/11x codes into LW.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    if (f3[1])      return SZ_WORD;
    else if (f3[0]) return SZ_HALF;
    else            return SZ_BYTE;
  endfunction

  function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

  // Lane offset after forcing the access onto its natural boundary.
  function automatic logic [1:0] natural_offset(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return {off[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return BE_HALF << {off[1], 1'b0};
      SZ_WORD: return BE_WORD;
      default: return BE_BYTE << off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: selects the addressed lane of a read word and sign- or
// zero-extends it according to funct3. Shared by the uncached path and any later cache path.
module lsu_load_align
  import riscy_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic [BUS_WIDTH-1:0] rdata,
  input  logic [1:0]           offset,
  input  logic [2:0]           funct3,
  output logic [BUS_WIDTH-1:0] load_data
);

  logic [BUS_WIDTH-1:0] shifted;
  logic                 sign_en;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    shifted   = rdata >> {offset, 3'b000};
    sign_en   = ~funct3[2];
    load_data = shifted;
    case (f3_size(funct3))
      SZ_BYTE: load_data = {{(BUS_WIDTH-8){sign_en & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{(BUS_WIDTH-16){sign_en & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one access at a time to a single-port data memory over req/ack.
// Optional MISALIGN_TRAP_EN rejects misaligned half/word accesses and adds misalign_err.
module load_store_unit
  import riscy_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0]  store_data,
  output logic                  stall,
  output logic                  load_valid,
  output logic [BUS_WIDTH-1:0]  load_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_ack
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  misalign_err
`endif
);

  lsu_state_t           state;
  logic [2:0]           funct3_q;
  logic [1:0]           off_q;
  logic                 is_store_q;

  lsu_size_t            req_size;
  logic [1:0]           req_off;
  logic [3:0]           req_be;
  logic [BUS_WIDTH-1:0] req_wdata;
  logic                 issue;
  logic [BUS_WIDTH-1:0] align_data;

  // Request decode from the execute-stage operands, registered on acceptance.
  always_comb begin
    req_size  = f3_size(funct3);
    req_off   = natural_offset(req_size, addr[1:0]);
    req_be    = byte_enables(req_size, addr[1:0]);
    req_wdata = store_data;
    case (req_size)
      SZ_BYTE: req_wdata = {(BUS_WIDTH/8){store_data[7:0]}};
      SZ_HALF: req_wdata = {(BUS_WIDTH/16){store_data[15:0]}};
      default: req_wdata = store_data;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic trap;
  assign trap  = req_valid & is_misaligned(req_size, addr[1:0]);
  assign issue = req_valid & ~trap;
`else
  assign issue = req_valid;
`endif

  lsu_load_align #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_load_align (
    .rdata    (mem_rdata),
    .offset   (off_q),
    .funct3   (funct3_q),
    .load_data(align_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state      <= IDLE;
      funct3_q   <= '0;
      off_q      <= '0;
      is_store_q <= 1'b0;
      stall      <= 1'b0;
      load_valid <= 1'b0;
      load_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      load_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_err <= trap;
`endif
      case (state)
        IDLE: begin
          if (issue) begin
            funct3_q   <= funct3;
            off_q      <= req_off;
            is_store_q <= is_store;
            mem_req    <= 1'b1;
            mem_we     <= is_store;
            mem_addr   <= {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be     <= req_be;
            mem_wdata  <= req_wdata;
            stall      <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // Extraction happens on the ack edge so load_valid lines up with the DONE cycle.
          if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            stall      <= 1'b0;
            load_valid <= ~is_store_q;
            if (!is_store_q) load_data <= align_data;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
